// File: rtl/sm83_irq_ctrl.sv
// SM83 interrupt controller: IF/IE/IME registers, trigger edge detection and a
// three-state dispatch FSM whose winner is chosen at resolve time, not at start.
module sm83_irq_ctrl #(
  parameter int unsigned NUM_IRQ   = 8,
  parameter logic [15:0] VEC_BASE  = 16'h0040,
  parameter int unsigned VEC_SHIFT = 3,
  parameter logic [15:0] IE_ADDR   = 16'hFFFF,
  parameter logic [15:0] IF_ADDR   = 16'hFF0F
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic [15:0]        A,
  input  logic [7:0]         D_IN,
  output logic [7:0]         D_OUT,
  output logic               D_OE,
  input  logic               RD,
  input  logic               WR,
  input  logic [NUM_IRQ-1:0] IRQ_TRIG,
  output logic [NUM_IRQ-1:0] IRQ_ACK,
  input  logic               EI,
  input  logic               DI,
  input  logic               RETI,
  input  logic               INSTR_DONE,
  input  logic               INT_START,
  input  logic               INT_RESOLVE,
  output logic               IRQ_PEND,
  output logic               WAKE_REQ,
  output logic               VEC_VALID,
  output logic [15:0]        VECTOR
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_RES, ST_VEC} state_t;

  state_t             state, state_next;
  logic [NUM_IRQ-1:0] trig_q;
  logic [NUM_IRQ-1:0] if_r;
  logic [7:0]         ie_r;
  logic               ime, ei_pend;

  logic [NUM_IRQ-1:0] set, m, res_clr, win_onehot, if_next;
  logic [2:0]         winner;
  logic               found;
  logic               start_acc, resolve_acc;
  logic               hit_if, hit_ie;
  logic [7:0]         rd_if;
  logic [15:0]        vec_next;

  assign set         = IRQ_TRIG & ~trig_q;
  assign m           = if_r & ie_r[NUM_IRQ-1:0];
  assign start_acc   = (state == ST_IDLE) && INT_START;
  assign resolve_acc = (state == ST_WAIT_RES) && INT_RESOLVE;

  // Lowest index wins; evaluated live so late IE/IF changes can retarget or cancel.
  always_comb begin
    winner     = '0;
    found      = 1'b0;
    win_onehot = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (m[i] && !found) begin
        winner        = 3'(i);
        found         = 1'b1;
        win_onehot[i] = 1'b1;
      end
    end
  end

  assign res_clr  = resolve_acc ? win_onehot : '0;
  assign vec_next = found ? (VEC_BASE + (16'(winner) << VEC_SHIFT)) : 16'h0000;

  always_comb begin
    if_next = (WR && (A == IF_ADDR)) ? D_IN[NUM_IRQ-1:0] : if_r;
    if_next = (if_next & ~res_clr) | set;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (INT_START)   state_next = ST_WAIT_RES;
      ST_WAIT_RES: if (INT_RESOLVE) state_next = ST_VEC;
      ST_VEC:      state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      trig_q    <= '0;
      if_r      <= '0;
      ie_r      <= '0;
      ime       <= 1'b0;
      ei_pend   <= 1'b0;
      IRQ_ACK   <= '0;
      IRQ_PEND  <= 1'b0;
      WAKE_REQ  <= 1'b0;
      VEC_VALID <= 1'b0;
      VECTOR    <= '0;
    end else begin
      trig_q <= IRQ_TRIG;
      if_r   <= if_next;
      if (WR && (A == IE_ADDR)) ie_r <= D_IN;

      // DI and dispatch start override everything; EI arms only after the current
      // INSTR_DONE so an EI/INSTR_DONE coincidence still delays one instruction.
      if (DI || start_acc) begin
        ime     <= 1'b0;
        ei_pend <= 1'b0;
      end else begin
        if (RETI || (INSTR_DONE && ei_pend)) ime <= 1'b1;
        if (EI)                              ei_pend <= 1'b1;
        else if (INSTR_DONE)                 ei_pend <= 1'b0;
      end

      IRQ_PEND  <= ime && (|m) && (state == ST_IDLE);
      WAKE_REQ  <= |m;
      IRQ_ACK   <= res_clr;
      VEC_VALID <= resolve_acc;
      if (resolve_acc) VECTOR <= vec_next;
    end
  end

  always_comb begin
    rd_if              = '1;
    rd_if[NUM_IRQ-1:0] = if_r;
    hit_if             = (A == IF_ADDR);
    hit_ie             = (A == IE_ADDR);
    D_OE               = nRESET && RD && (hit_if || hit_ie);
    if (!D_OE)       D_OUT = 8'hFF;
    else if (hit_if) D_OUT = rd_if;
    else             D_OUT = ie_r;
  end

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Bench for sm83_irq_ctrl (NUM_IRQ=5): directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a behavioural model.
module tb_sm83_irq_ctrl;

  localparam int unsigned N       = 5;
  localparam logic [15:0] IF_A    = 16'hFF0F;
  localparam logic [15:0] IE_A    = 16'hFFFF;
  localparam logic [7:0]  MASK    = 8'h1F;
  localparam logic [7:0]  HI_FILL = 8'hE0;

  logic         CLK = 1'b0;
  logic         nRESET = 1'b0;
  logic [15:0]  A = '0;
  logic [7:0]   D_IN = '0;
  logic [7:0]   D_OUT;
  logic         D_OE;
  logic         RD = 1'b0, WR = 1'b0;
  logic [N-1:0] IRQ_TRIG = '0;
  logic [N-1:0] IRQ_ACK;
  logic         EI = 1'b0, DI = 1'b0, RETI = 1'b0, INSTR_DONE = 1'b0;
  logic         INT_START = 1'b0, INT_RESOLVE = 1'b0;
  logic         IRQ_PEND, WAKE_REQ, VEC_VALID;
  logic [15:0]  VECTOR;

  int n_checks = 0;
  int n_pass   = 0;
  logic cmp_en = 1'b0;

  sm83_irq_ctrl #(.NUM_IRQ(N)) dut (
    .CLK(CLK), .nRESET(nRESET), .A(A), .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE),
    .RD(RD), .WR(WR), .IRQ_TRIG(IRQ_TRIG), .IRQ_ACK(IRQ_ACK), .EI(EI), .DI(DI),
    .RETI(RETI), .INSTR_DONE(INSTR_DONE), .INT_START(INT_START),
    .INT_RESOLVE(INT_RESOLVE), .IRQ_PEND(IRQ_PEND), .WAKE_REQ(WAKE_REQ),
    .VEC_VALID(VEC_VALID), .VECTOR(VECTOR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: register contents as plain bytes, dispatch as a phase counter.
  logic [7:0]  mdl_if = '0, mdl_ie = '0, mdl_prev = '0;
  bit          mdl_ime = 0, mdl_armed = 0;
  int          mdl_phase = 0;      // 0 idle, 1 awaiting resolve, 2 vector cycle
  logic [7:0]  e_ack = '0;
  bit          e_pend = 0, e_wake = 0, e_vv = 0;
  logic [15:0] e_vec = '0;

  always @(posedge CLK or negedge nRESET) begin
    logic [7:0] pm, rises, nxt_if;
    int lowest;
    bit do_start, do_res;
    if (!nRESET) begin
      mdl_if = '0; mdl_ie = '0; mdl_prev = '0; mdl_ime = 0; mdl_armed = 0;
      mdl_phase = 0; e_ack = '0; e_pend = 0; e_wake = 0; e_vv = 0; e_vec = '0;
    end else begin
      pm = mdl_if & mdl_ie & MASK;
      lowest = -1;
      for (int i = N - 1; i >= 0; i--) if (pm[i]) lowest = i;
      rises    = {3'b000, IRQ_TRIG} & ~mdl_prev;
      do_start = (mdl_phase == 0) && INT_START;
      do_res   = (mdl_phase == 1) && INT_RESOLVE;

      e_pend = mdl_ime && (pm != 0) && (mdl_phase == 0);
      e_wake = (pm != 0);
      e_ack  = '0;
      e_vv   = do_res;

      nxt_if = (WR && A == IF_A) ? (D_IN & MASK) : mdl_if;
      if (do_res) begin
        if (lowest >= 0) begin
          e_ack = 8'(1 << lowest);
          e_vec = 16'h0040 + 16'(lowest * 8);
          nxt_if[lowest] = 1'b0;
        end else begin
          e_vec = 16'h0000;
        end
      end
      mdl_if = nxt_if | rises;
      if (WR && A == IE_A) mdl_ie = D_IN;

      if (DI || do_start) begin
        mdl_ime = 0; mdl_armed = 0;
      end else begin
        if (RETI) mdl_ime = 1;
        if (INSTR_DONE && mdl_armed) begin mdl_ime = 1; mdl_armed = 0; end
        if (EI) mdl_armed = 1;
      end

      mdl_prev = {3'b000, IRQ_TRIG};
      if (do_start)             mdl_phase = 1;
      else if (do_res)          mdl_phase = 2;
      else if (mdl_phase == 2)  mdl_phase = 0;
    end
  end

  always @(negedge CLK) begin
    logic [7:0] x_out;
    logic x_oe;
    if (cmp_en) begin
      x_oe  = nRESET && RD && (A == IF_A || A == IE_A);
      x_out = !x_oe ? 8'hFF : (A == IF_A) ? (HI_FILL | mdl_if) : mdl_ie;
      chk("cyc_d_oe",  32'(D_OE), 32'(x_oe));
      chk("cyc_d_out", 32'(D_OUT), 32'(x_out));
      chk("cyc_ack",   32'(IRQ_ACK), 32'(e_ack));
      chk("cyc_pend",  32'(IRQ_PEND), 32'(e_pend));
      chk("cyc_wake",  32'(WAKE_REQ), 32'(e_wake));
      chk("cyc_vv",    32'(VEC_VALID), 32'(e_vv));
      chk("cyc_vec",   32'(VECTOR), 32'(e_vec));
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
    WR = 0; EI = 0; DI = 0; RETI = 0; INSTR_DONE = 0; INT_START = 0; INT_RESOLVE = 0;
  endtask

  task automatic wr_reg(input logic [15:0] addr, input logic [7:0] data);
    A = addr; D_IN = data; WR = 1;
    step();
  endtask

  task automatic rd_chk(input string name, input logic [15:0] addr, input logic [7:0] exp);
    A = addr; RD = 1;
    #1;
    chk(name, 32'(D_OUT), 32'(exp));
    RD = 0;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    #1;
    cmp_en = 1;
    chk("rst_ack", 32'(IRQ_ACK), 0);
    chk("rst_vec", 32'(VECTOR), 0);
    chk("rst_vv", 32'(VEC_VALID), 0);
    rd_chk("rst_dout", IF_A, 8'hFF);
    nRESET = 1;
    step();

    // IE=01, IME via RETI, rising trigger on line 0
    wr_reg(IE_A, 8'h01);
    RETI = 1; step();
    IRQ_TRIG = 5'b00001; step();
    rd_chk("trig_if", IF_A, 8'hE1);
    chk("pend_1cyc", 32'(IRQ_PEND), 0);
    step();
    chk("pend_2cyc", 32'(IRQ_PEND), 1);
    chk("model_if", 32'(mdl_if), 32'h01);

    // two dispatches with IF=IE=05
    wr_reg(IF_A, 8'h05);
    wr_reg(IE_A, 8'h05);
    INT_START = 1; step();
    INT_RESOLVE = 1; step();
    chk("d1_vv", 32'(VEC_VALID), 1);
    chk("d1_vec", 32'(VECTOR), 32'h0040);
    chk("d1_ack", 32'(IRQ_ACK), 32'h01);
    rd_chk("d1_if", IF_A, 8'hE4);
    step();
    chk("d1_vv_drop", 32'(VEC_VALID), 0);
    chk("d1_ack_drop", 32'(IRQ_ACK), 0);
    chk("d1_vec_hold", 32'(VECTOR), 32'h0040);
    INT_START = 1; step();
    INT_RESOLVE = 1; step();
    chk("d2_vec", 32'(VECTOR), 32'h0050);
    chk("d2_ack", 32'(IRQ_ACK), 32'h04);
    chk("model_vec", 32'(e_vec), 32'h0050);

    // dispatch cancelled by IE cleared while awaiting resolve
    wr_reg(IF_A, 8'h01);
    INT_START = 1; step();
    wr_reg(IE_A, 8'h00);
    INT_RESOLVE = 1; step();
    chk("cx_vv", 32'(VEC_VALID), 1);
    chk("cx_vec", 32'(VECTOR), 0);
    chk("cx_ack", 32'(IRQ_ACK), 0);
    rd_chk("cx_if", IF_A, 8'hE1);

    // delayed EI
    wr_reg(IE_A, 8'h01);
    EI = 1; INSTR_DONE = 1; step();
    step();
    chk("ei_same_cyc", 32'(IRQ_PEND), 0);
    INSTR_DONE = 1; step();
    step();
    chk("ei_next_instr", 32'(IRQ_PEND), 1);
    DI = 1; EI = 1; step();
    step();
    chk("di_beats_ei", 32'(IRQ_PEND), 0);
    INSTR_DONE = 1; step();
    step();
    chk("di_clr_armed", 32'(IRQ_PEND), 0);

    // trigger edge beats a simultaneous IF write of 00
    IRQ_TRIG = '0; step();
    IRQ_TRIG = 5'b00010; A = IF_A; D_IN = 8'h00; WR = 1; step();
    rd_chk("set_wins", IF_A, 8'hE2);
    IRQ_TRIG = '0; step();

    // reset while awaiting resolve
    wr_reg(IE_A, 8'h02);
    INT_START = 1; step();
    chk("pre_rst_wake", 32'(WAKE_REQ), 1);
    nRESET = 0;
    #1;
    chk("mid_rst_wake", 32'(WAKE_REQ), 0);
    chk("mid_rst_vv", 32'(VEC_VALID), 0);
    step();
    nRESET = 1; step();
    INT_RESOLVE = 1; step();
    chk("post_rst_vv", 32'(VEC_VALID), 0);
    chk("post_rst_ack", 32'(IRQ_ACK), 0);
    rd_chk("post_rst_if", IF_A, 8'hE0);

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      case ($urandom_range(0, 3))
        0, 1:    A = ($urandom_range(0, 1) == 0) ? IF_A : IE_A;
        default: A = 16'($urandom);
      endcase
      D_IN        = 8'($urandom);
      RD          = ($urandom_range(0, 1) == 1);
      WR          = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 2) == 0) IRQ_TRIG = IRQ_TRIG ^ N'(1 << $urandom_range(0, N - 1));
      EI          = ($urandom_range(0, 7) == 0);
      DI          = ($urandom_range(0, 11) == 0);
      RETI        = ($urandom_range(0, 9) == 0);
      INSTR_DONE  = ($urandom_range(0, 3) == 0);
      INT_START   = ($urandom_range(0, 3) == 0);
      INT_RESOLVE = ($urandom_range(0, 2) == 0);
      nRESET      = ($urandom_range(0, 299) != 0);
      step();
      nRESET = 1;
    end

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
